// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses,
// architectural bit positions inside mstatus/mie/mip, interrupt cause codes
// and the mtvec mode encoding.
package csr_pkg;

    // CSR addresses (instruction bits [31:20])
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIX_MT       = 7;   // MTIE in mie, MTIP in mip
    localparam int MIX_ME       = 11;  // MEIE in mie, MEIP in mip

    // Interrupt cause codes (low bits of mcause)
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // mtvec[1:0]; reserved encodings behave as direct
    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1,
        MTVEC_RSVD2    = 2'd2,
        MTVEC_RSVD3    = 2'd3
    } mtvec_mode_e;

endpackage

// File: rtl/intr_sync.sv
// Multi-flop synchronizer for one asynchronous interrupt level.
// Ports:
//   clk      in  clock
//   reset    in  synchronous, active-high reset (clears the chain)
//   async_in in  asynchronous level input
//   sync_out out synchronized level, SYNC_STAGES cycles after async_in
module intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain_r;

    // Shift the asynchronous level through the flop chain
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap/return sequencer for the MW stage.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr_valid         MW slot holds a real instruction
//   csr_reg_wr/rd       CSR write / read at csr_addr this cycle
//   is_mret             MW instruction is MRET
//   csr_addr, csr_wdata CSR address and final write value
//   npc                 next PC of the MW instruction (saved to mepc on a trap)
//   timer_intr/ext_intr asynchronous interrupt levels
//   csr_rdata           combinational read data (0 when not reading)
//   epc_taken, epc      combinational fetch redirect request and target
module csr_unit
    import csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic            csr_reg_wr,
    input  logic            csr_reg_rd,
    input  logic            is_mret,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] npc,
    input  logic            timer_intr,
    input  logic            ext_intr,
    output logic [XLEN-1:0] csr_rdata,
    output logic            epc_taken,
    output logic [XLEN-1:0] epc
);

    logic            mstatus_mie_r, mstatus_mpie_r;
    logic            mie_mtie_r, mie_meie_r;
    logic [XLEN-1:0] mtvec_r, mepc_r, mcause_r;
    logic            mip_mtip_s, mip_meip_s;
    logic            mip_mtip_d_r, mip_meip_d_r;
    logic [XLEN-1:0] mstatus_s, mie_s, mip_s;
    logic            pend_mti_s, pend_mei_s, irq_take_s, mret_fire_s, sw_wr_s;
    logic [3:0]      cause_s;
    logic [XLEN-1:0] trap_base_s;
    mtvec_mode_e     mtvec_mode_s;

    intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_timer (
        .clk(clk), .reset(reset), .async_in(timer_intr), .sync_out(mip_mtip_s)
    );
    intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
        .clk(clk), .reset(reset), .async_in(ext_intr), .sync_out(mip_meip_s)
    );

    // Assemble the architectural views of the sparse CSRs
    always_comb begin
        mstatus_s               = '0;
        mstatus_s[MSTATUS_MIE]  = mstatus_mie_r;
        mstatus_s[MSTATUS_MPIE] = mstatus_mpie_r;
        mie_s                   = '0;
        mie_s[MIX_MT]           = mie_mtie_r;
        mie_s[MIX_ME]           = mie_meie_r;
        mip_s                   = '0;
        mip_s[MIX_MT]           = mip_mtip_s;
        mip_s[MIX_ME]           = mip_meip_s;
    end

    // The take path requires a line to have been visible in mip for a full
    // cycle, so an interrupt is first taken the cycle after mip shows it.
    // Gating on the live mip as well stops a line that already dropped.
    assign pend_mti_s  = mstatus_mie_r & mie_mtie_r & mip_mtip_s & mip_mtip_d_r;
    assign pend_mei_s  = mstatus_mie_r & mie_meie_r & mip_meip_s & mip_meip_d_r;
    // Reset suppresses any redirect in the cycle it is asserted
    assign irq_take_s  = (pend_mti_s | pend_mei_s) & instr_valid & ~is_mret & ~reset;
    assign mret_fire_s = is_mret & instr_valid & ~reset;
    assign sw_wr_s     = csr_reg_wr & instr_valid;
    assign cause_s     = pend_mei_s ? CAUSE_MEI : CAUSE_MTI;
    assign mtvec_mode_s = mtvec_mode_e'(mtvec_r[1:0]);
    assign trap_base_s = {mtvec_r[XLEN-1:2], 2'b00};
    assign epc_taken   = irq_take_s | mret_fire_s;

    // Redirect target: trap vector for interrupts, mepc for MRET
    always_comb begin
        epc = '0;
        if (irq_take_s) begin
            case (mtvec_mode_s)
                MTVEC_VECTORED: epc = trap_base_s + {{(XLEN-6){1'b0}}, cause_s, 2'b00};
                default:        epc = trap_base_s;
            endcase
        end else if (mret_fire_s) begin
            epc = mepc_r;
        end else begin
            epc = '0;
        end
    end

    // CSR read mux; unimplemented addresses read zero
    always_comb begin
        csr_rdata = '0;
        if (csr_reg_rd) begin
            case (csr_addr)
                CSR_MSTATUS: csr_rdata = mstatus_s;
                CSR_MIE:     csr_rdata = mie_s;
                CSR_MTVEC:   csr_rdata = mtvec_r;
                CSR_MEPC:    csr_rdata = mepc_r;
                CSR_MCAUSE:  csr_rdata = mcause_r;
                CSR_MIP:     csr_rdata = mip_s;
                default:     csr_rdata = '0;
            endcase
        end else begin
            csr_rdata = '0;
        end
    end

    // CSR state: software writes, then trap/MRET updates which take priority
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_mtie_r     <= 1'b0;
            mie_meie_r     <= 1'b0;
            mtvec_r        <= '0;
            mepc_r         <= '0;
            mcause_r       <= '0;
            mip_mtip_d_r   <= 1'b0;
            mip_meip_d_r   <= 1'b0;
        end else begin
            mip_mtip_d_r <= mip_mtip_s;
            mip_meip_d_r <= mip_meip_s;
            if (sw_wr_s) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        if (!irq_take_s && !mret_fire_s) begin
                            mstatus_mie_r  <= csr_wdata[MSTATUS_MIE];
                            mstatus_mpie_r <= csr_wdata[MSTATUS_MPIE];
                        end
                    end
                    CSR_MIE: begin
                        mie_mtie_r <= csr_wdata[MIX_MT];
                        mie_meie_r <= csr_wdata[MIX_ME];
                    end
                    CSR_MTVEC:  mtvec_r <= csr_wdata;
                    CSR_MEPC:   if (!irq_take_s) mepc_r <= {csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: if (!irq_take_s) mcause_r <= csr_wdata;
                    default: ;
                endcase
            end
            if (irq_take_s) begin
                mepc_r         <= {npc[XLEN-1:2], 2'b00};
                mcause_r       <= {1'b1, {(XLEN-5){1'b0}}, cause_s};
                mstatus_mpie_r <= mstatus_mie_r;
                mstatus_mie_r  <= 1'b0;
            end else if (mret_fire_s) begin
                mstatus_mie_r  <= mstatus_mpie_r;
                mstatus_mpie_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit. Inputs change on the falling
// edge; outputs are checked 1 time unit later, well away from the rising edge.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        csr_reg_wr = 1'b0;
    logic        csr_reg_rd = 1'b0;
    logic        is_mret = 1'b0;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] npc = 32'h0;
    logic        timer_intr = 1'b0;
    logic        ext_intr = 1'b0;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc;

    int n_cmp = 0;
    int n_bad = 0;

    csr_unit #(.XLEN(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .csr_reg_wr(csr_reg_wr), .csr_reg_rd(csr_reg_rd), .is_mret(is_mret),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .npc(npc),
        .timer_intr(timer_intr), .ext_intr(ext_intr),
        .csr_rdata(csr_rdata), .epc_taken(epc_taken), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic r, input logic m,
                         input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        instr_valid = v; csr_reg_wr = w; csr_reg_rd = r; is_mret = m;
        csr_addr = a; csr_wdata = d;
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, 1'b0, 1'b0, a, d);
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string tag);
        drive(1'b0, 1'b0, 1'b1, 1'b0, a, 32'h0);
        chk(csr_rdata, exp, tag);
    endtask

    initial begin
        // 1. reset state
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        rd_chk(12'h300, 32'h0, "rst_mstatus");
        chk({31'b0, epc_taken}, 32'h0, "rst_epc_taken");
        chk(epc, 32'h0, "rst_epc");
        rd_chk(12'h304, 32'h0, "rst_mie");
        rd_chk(12'h305, 32'h0, "rst_mtvec");
        rd_chk(12'h341, 32'h0, "rst_mepc");
        rd_chk(12'h342, 32'h0, "rst_mcause");
        rd_chk(12'h344, 32'h0, "rst_mip");

        // 2. vectored timer interrupt, latency from line rise
        wr(12'h305, 32'h0000_1001);
        wr(12'h304, 32'h0000_0080);
        wr(12'h300, 32'h0000_0008);
        rd_chk(12'h305, 32'h0000_1001, "mtvec_rb");
        rd_chk(12'h300, 32'h0000_0008, "mstatus_rb");
        npc = 32'h0000_0400;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        timer_intr = 1'b1;
        chk({31'b0, epc_taken}, 32'h0, "lat_c0");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk({31'b0, epc_taken}, 32'h0, "lat_c1");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 12'h344, 32'h0);
        chk({31'b0, epc_taken}, 32'h0, "lat_c2");
        chk(csr_rdata, 32'h0000_0080, "mip_mtip");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk({31'b0, epc_taken}, 32'h1, "lat_c3_take");
        chk(epc, 32'h0000_101C, "vec_epc");
        rd_chk(12'h341, 32'h0000_0400, "take_mepc");
        chk({31'b0, epc_taken}, 32'h0, "bubble_no_take");
        rd_chk(12'h342, 32'h8000_0007, "take_mcause");
        rd_chk(12'h300, 32'h0000_0080, "take_mstatus");

        // 4. mret with timer still pending
        wr(12'h341, 32'h0000_0200);
        npc = 32'h0000_0500;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 32'h0);
        chk({31'b0, epc_taken}, 32'h1, "mret_taken");
        chk(epc, 32'h0000_0200, "mret_epc");
        // 5. next valid cycle traps; a same-cycle mstatus write loses
        npc = 32'h0000_0600;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h300, 32'h0);
        chk(csr_rdata, 32'h0000_0088, "post_mret_mstatus");
        chk({31'b0, epc_taken}, 32'h1, "retake_after_mret");
        chk(epc, 32'h0000_101C, "retake_epc");
        rd_chk(12'h300, 32'h0000_0080, "hw_wins_mstatus");
        rd_chk(12'h341, 32'h0000_0600, "retake_mepc");
        wr(12'h123, 32'hDEAD_BEEF);
        rd_chk(12'h123, 32'h0, "unimpl_read");

        // 3. external + timer together, direct mode
        timer_intr = 1'b0;
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        wr(12'h305, 32'h0000_2000);
        wr(12'h304, 32'h0000_0880);
        wr(12'h300, 32'h0000_0008);
        npc = 32'h0000_0700;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        timer_intr = 1'b1; ext_intr = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk({31'b0, epc_taken}, 32'h0, "both_c2");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk({31'b0, epc_taken}, 32'h1, "both_take");
        chk(epc, 32'h0000_2000, "direct_epc");
        rd_chk(12'h342, 32'h8000_000B, "ext_priority");
        rd_chk(12'h344, 32'h0000_0880, "mip_both");

        // 6. bubbles hold off a pending interrupt; reserved mode acts direct
        wr(12'h305, 32'h0000_3002);
        wr(12'h300, 32'h0000_0008);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
            chk({31'b0, epc_taken}, 32'h0, "bubble_hold");
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk({31'b0, epc_taken}, 32'h1, "first_valid_take");
        chk(epc, 32'h0000_3000, "rsvd_mode_epc");
        wr(12'h300, 32'h0000_0008);
        // reset in a cycle that would otherwise trap
        @(negedge clk);
        instr_valid = 1'b1; csr_reg_wr = 1'b0; csr_reg_rd = 1'b0; is_mret = 1'b0;
        reset = 1'b1; timer_intr = 1'b0; ext_intr = 1'b0;
        #1;
        chk({31'b0, epc_taken}, 32'h0, "reset_no_redirect");
        @(negedge clk); reset = 1'b0;
        rd_chk(12'h300, 32'h0, "post_rst_mstatus");
        rd_chk(12'h304, 32'h0, "post_rst_mie");
        rd_chk(12'h305, 32'h0, "post_rst_mtvec");
        rd_chk(12'h341, 32'h0, "post_rst_mepc");
        rd_chk(12'h342, 32'h0, "post_rst_mcause");
        rd_chk(12'h344, 32'h0, "post_rst_mip");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
